// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port video RAM between the display line-fetch path and
// the CPU/host port, all in the pixel clock domain.
//
// Grant policy:
//   - In active video the display path normally wins. A pending CPU request
//     that has been refused STARVE_MAX times in a row is forced through.
//   - During blanking the CPU wins.
//   - Either side wins if the other is not requesting.
// Grants are combinational, so a requester sees its grant in the same cycle.
// The access reaches the memory port one cycle later. Read data returns to
// its owner one cycle after that.
//
// Ports:
//   clk_i, rst_i          pixel clock, async active-high reset
//   blank_i               high outside the active display region
//   disp_req_i/addr_i     display read request and address
//   disp_gnt_o            display request accepted this cycle
//   disp_rvalid_o/rdata_o display read return
//   cpu_req_i/we_i/addr_i/wdata_i  CPU request (write when we_i=1)
//   cpu_gnt_o             CPU request accepted this cycle
//   cpu_rvalid_o/rdata_o  CPU read return
//   mem_en_o/we_o/addr_o/wdata_o   registered VRAM access port
//   mem_rdata_i           VRAM read data, valid the cycle after a read strobe
module vram_arbiter #(
  parameter int AW         = 17,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          blank_i,
  input  logic          disp_req_i,
  input  logic [AW-1:0] disp_addr_i,
  output logic          disp_gnt_o,
  output logic          disp_rvalid_o,
  output logic [DW-1:0] disp_rdata_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int            SW           = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          cpu_win;
  logic          disp_win;

  // Owner tag and read flag for the access currently on the memory port.
  logic          tag_cpu;
  logic          rd_flag;

  // Return stage: which side is receiving read data this cycle.
  logic          ret_cpu;
  logic          ret_disp;
  logic [DW-1:0] cpu_hold;
  logic [DW-1:0] disp_hold;

  // The grant decision is combinational and depends only on current inputs
  // and the registered starve count. Reset forces both grants low, so no
  // access can be launched while reset is held.
  always_comb begin
    cpu_win  = 1'b0;
    disp_win = 1'b0;
    if (!rst_i) begin
      cpu_win  = cpu_req_i && (blank_i || (starve_cnt == STARVE_LIMIT) || !disp_req_i);
      disp_win = disp_req_i && !cpu_win;
    end
  end

  assign cpu_gnt_o  = cpu_win;
  assign disp_gnt_o = disp_win;

  // The starve count measures how many consecutive cycles a pending CPU
  // request has been refused. It saturates at the limit, where the grant
  // logic forces the CPU through.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (cpu_req_i && !cpu_win) begin
      if (starve_cnt != STARVE_LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Memory issue stage. The winning request is registered onto the VRAM
  // port. Idle cycles drop the strobes but keep address and data stable.
  // Display accesses are always reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      tag_cpu     <= 1'b0;
      rd_flag     <= 1'b0;
    end else if (cpu_win) begin
      mem_en_o    <= 1'b1;
      mem_we_o    <= cpu_we_i;
      mem_addr_o  <= cpu_addr_i;
      mem_wdata_o <= cpu_wdata_i;
      tag_cpu     <= 1'b1;
      rd_flag     <= !cpu_we_i;
    end else if (disp_win) begin
      mem_en_o    <= 1'b1;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= disp_addr_i;
      tag_cpu     <= 1'b0;
      rd_flag     <= 1'b1;
    end else begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      rd_flag     <= 1'b0;
    end
  end

  // Return stage. The read flag and owner tag advance one more cycle, which
  // lines them up with the word the VRAM presents. The word is also latched
  // so that rdata holds its last value between pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ret_cpu   <= 1'b0;
      ret_disp  <= 1'b0;
      cpu_hold  <= '0;
      disp_hold <= '0;
    end else begin
      ret_cpu  <= rd_flag && tag_cpu;
      ret_disp <= rd_flag && !tag_cpu;
      if (ret_cpu) begin
        cpu_hold <= mem_rdata_i;
      end
      if (ret_disp) begin
        disp_hold <= mem_rdata_i;
      end
    end
  end

  // During the return cycle the word comes straight from the VRAM, which
  // keeps grant-to-data latency at two cycles. At all other times the
  // latched copy is shown.
  assign cpu_rvalid_o  = ret_cpu;
  assign disp_rvalid_o = ret_disp;
  assign cpu_rdata_o   = ret_cpu  ? mem_rdata_i : cpu_hold;
  assign disp_rdata_o  = ret_disp ? mem_rdata_i : disp_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Testbench for vram_arbiter. It provides a behavioural VRAM and a
// transaction-level reference model: grant rule, starve count, shadow memory
// and a queue of expected read returns.
module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 16;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          blank;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_i(rst), .blank_i(blank),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr), .disp_gnt_o(disp_gnt),
    .disp_rvalid_o(disp_rvalid), .disp_rdata_o(disp_rdata),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt),
    .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Power-up content of every VRAM word, derived from its address.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // Behavioural single-port VRAM: read data appears the cycle after the strobe.
  logic [DW-1:0] vram [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] = mem_wdata;
      else        mem_rdata <= vram.exists(mem_addr) ? vram[mem_addr] : init_word(mem_addr);
    end
  end

  // Reference model state.
  typedef struct {
    int            due;
    bit            cpu;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  int            cyc       = 0;
  int            m_starve  = 0;
  logic [DW-1:0] m_last_cpu  = '0;
  logic [DW-1:0] m_last_disp = '0;
  bit            m_cg = 0;
  bit            m_dg = 0;

  function automatic logic [DW-1:0] rd_shadow(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  function automatic bit exp_cpu_gnt();
    if (rst) return 1'b0;
    return cpu_req && (blank || m_starve == SM || !disp_req);
  endfunction

  function automatic bit exp_disp_gnt();
    if (rst) return 1'b0;
    return disp_req && !exp_cpu_gnt();
  endfunction

  function automatic bit exp_rv(input bit side_cpu);
    return pend.size() > 0 && pend[0].due == cyc && pend[0].cpu == side_cpu;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input bit side_cpu);
    if (exp_rv(side_cpu)) return pend[0].data;
    return side_cpu ? m_last_cpu : m_last_disp;
  endfunction

  // Advances the reference model by one clock using the current inputs, then
  // moves to 1 time unit after the next rising edge.
  task automatic tick();
    bit cg;
    bit dg;
    cg = 1'b0;
    dg = 1'b0;
    if (rst) begin
      pend.delete();
      m_starve    = 0;
      m_last_cpu  = '0;
      m_last_disp = '0;
    end else begin
      cg = exp_cpu_gnt();
      dg = exp_disp_gnt();
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].cpu) m_last_cpu = pend[0].data;
        else             m_last_disp = pend[0].data;
        void'(pend.pop_front());
      end
      if (cg) begin
        m_starve = 0;
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
        else pend.push_back('{due: cyc + 2, cpu: 1'b1, data: rd_shadow(cpu_addr)});
      end else if (cpu_req) begin
        m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      end else begin
        m_starve = 0;
      end
      if (dg) pend.push_back('{due: cyc + 2, cpu: 1'b0, data: rd_shadow(disp_addr)});
    end
    m_cg = cg;
    m_dg = dg;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; blank = 1'b1; cpu_req = 1'b1; disp_req = 1'b1;
    #3;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_rvalid, cpu_rdata,
         disp_rvalid, disp_rdata, cpu_gnt, disp_gnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got en=%b we=%b addr=%h wd=%h crv=%b crd=%h drv=%b drd=%h cg=%b dg=%b required all 0",
               mem_en, mem_we, mem_addr, mem_wdata, cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata, cpu_gnt, disp_gnt);
    end
    tick();
    rst = 1'b0; cpu_req = 1'b0; disp_req = 1'b0; blank = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #3;
      checks++;
      if ({mem_en, cpu_rvalid, disp_rvalid, cpu_gnt, disp_gnt, cpu_rdata, disp_rdata} !== '0) begin
        failures++;
        $display("[TB] FAIL idle_outputs cyc=%0d got en=%b crv=%b drv=%b cg=%b dg=%b required all 0",
                 cyc, mem_en, cpu_rvalid, disp_rvalid, cpu_gnt, disp_gnt);
      end
      tick();
    end
    // Launch a display read, then reset while it sits on the memory port.
    disp_req = 1'b1; disp_addr = 17'h00055;
    #3;
    checks++;
    if (disp_gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_pre_gnt got %b required 1", disp_gnt);
    end
    tick();
    disp_req = 1'b0;
    #3;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 17'h00055) begin
      failures++;
      $display("[TB] FAIL reset_pre_strobe got en=%b addr=%h required en=1 addr=00055", mem_en, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_addr, disp_rvalid, disp_gnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_async got en=%b addr=%h drv=%b required 0", mem_en, mem_addr, disp_rvalid);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      checks++;
      if (disp_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || mem_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_discard cyc=%0d got drv=%b crv=%b en=%b required 0", cyc, disp_rvalid, cpu_rvalid, mem_en);
      end
      tick();
    end
  endtask

  task automatic test_cpu_write();
    for (int k = 0; k < 4; k++) begin
      blank = 1'b1; disp_req = 1'b0;
      cpu_req = (k == 0); cpu_we = 1'b1; cpu_addr = 17'h00010; cpu_wdata = 16'hBEEF;
      #3;
      checks++;
      if (cpu_gnt !== (k == 0) || disp_gnt !== 1'b0) begin
        failures++;
        $display("[TB] FAIL write_gnt k=%0d got cg=%b dg=%b required cg=%b dg=0", k, cpu_gnt, disp_gnt, k == 0);
      end
      if (k == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'h00010 || mem_wdata !== 16'hBEEF) begin
          failures++;
          $display("[TB] FAIL write_mem got en=%b we=%b addr=%h wd=%h required 1 1 00010 beef",
                   mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      checks++;
      if (cpu_rvalid !== 1'b0 || disp_rvalid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL write_no_rvalid k=%0d got crv=%b drv=%b required 0", k, cpu_rvalid, disp_rvalid);
      end
      tick();
    end
  endtask

  task automatic test_cpu_read();
    for (int k = 0; k < 4; k++) begin
      blank = 1'b1; disp_req = 1'b0;
      cpu_req = (k == 0); cpu_we = 1'b0; cpu_addr = 17'h00010;
      #3;
      if (k == 0) begin
        checks++;
        if (cpu_gnt !== 1'b1) begin
          failures++;
          $display("[TB] FAIL read_gnt got %b required 1", cpu_gnt);
        end
      end
      checks++;
      if (cpu_rvalid !== (k == 2) || disp_rvalid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL read_rvalid k=%0d got crv=%b drv=%b required crv=%b drv=0", k, cpu_rvalid, disp_rvalid, k == 2);
      end
      if (k >= 2) begin
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin
          failures++;
          $display("[TB] FAIL read_data k=%0d got %h required beef", k, cpu_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] next_addr;
    next_addr = 17'h00100;
    blank = 1'b1; cpu_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      disp_req = (next_addr < 17'h00104); disp_addr = next_addr;
      #3;
      checks++;
      if ({cpu_gnt, disp_gnt} !== {exp_cpu_gnt(), exp_disp_gnt()}) begin
        failures++;
        $display("[TB] FAIL b2b_gnt cyc=%0d got %b%b required %b%b", cyc, cpu_gnt, disp_gnt, exp_cpu_gnt(), exp_disp_gnt());
      end
      checks++;
      if (mem_en !== (k >= 1 && k <= 4) || (mem_en && (mem_we !== 1'b0 || mem_addr !== 17'h000FF + AW'(k)))) begin
        failures++;
        $display("[TB] FAIL b2b_mem k=%0d got en=%b we=%b addr=%h", k, mem_en, mem_we, mem_addr);
      end
      checks++;
      if (disp_rvalid !== (k >= 2 && k <= 5) ||
          (disp_rvalid && disp_rdata !== init_word(17'h000FE + AW'(k)))) begin
        failures++;
        $display("[TB] FAIL b2b_rvalid k=%0d got drv=%b drd=%h", k, disp_rvalid, disp_rdata);
      end
      tick();
      if (m_dg) next_addr++;
    end
    disp_req = 1'b0;
  endtask

  task automatic test_starvation();
    int run;
    int cpu_grants;
    int disp_grants;
    int disp_returns;
    logic [AW-1:0] next_rd;
    run = 0; cpu_grants = 0; disp_grants = 0; disp_returns = 0;
    next_rd = 17'h00200;
    blank = 1'b0; disp_req = 1'b1; disp_addr = 17'h00200;
    cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = AW'($urandom_range(16'h1000, 16'h10FF)); cpu_wdata = DW'($urandom);
    for (int k = 0; k < 44; k++) begin
      if (k >= 40) begin
        disp_req = 1'b0; cpu_req = 1'b0;
      end
      #3;
      checks++;
      if ({cpu_gnt, disp_gnt} !== {exp_cpu_gnt(), exp_disp_gnt()}) begin
        failures++;
        $display("[TB] FAIL starve_gnt cyc=%0d got %b%b required %b%b", cyc, cpu_gnt, disp_gnt, exp_cpu_gnt(), exp_disp_gnt());
      end
      if (cpu_gnt === 1'b1) begin
        cpu_grants++;
        checks++;
        if (run != SM) begin
          failures++;
          $display("[TB] FAIL starve_run cyc=%0d got %0d display grants before cpu required %0d", cyc, run, SM);
        end
        run = 0;
      end else if (disp_gnt === 1'b1) begin
        run++;
        disp_grants++;
      end
      if (disp_rvalid === 1'b1) begin
        disp_returns++;
        checks++;
        if (disp_rdata !== init_word(next_rd)) begin
          failures++;
          $display("[TB] FAIL starve_order cyc=%0d got %h required %h", cyc, disp_rdata, init_word(next_rd));
        end
        next_rd++;
      end
      checks++;
      if (cpu_rvalid !== exp_rv(1'b1) || cpu_rdata !== exp_rd(1'b1) ||
          disp_rvalid !== exp_rv(1'b0) || disp_rdata !== exp_rd(1'b0)) begin
        failures++;
        $display("[TB] FAIL starve_return cyc=%0d got crv=%b crd=%h drv=%b drd=%h required %b %h %b %h", cyc,
                 cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata, exp_rv(1'b1), exp_rd(1'b1), exp_rv(1'b0), exp_rd(1'b0));
      end
      tick();
      if (m_dg) disp_addr++;
      if (m_cg) begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(16'h1000, 16'h10FF)); cpu_wdata = DW'($urandom);
      end
    end
    checks++;
    if (cpu_grants != 4 || disp_returns != disp_grants) begin
      failures++;
      $display("[TB] FAIL starve_totals got cpu_grants=%0d returns=%0d required cpu_grants=4 returns=%0d",
               cpu_grants, disp_returns, disp_grants);
    end
  endtask

  task automatic test_blank_toggle();
    disp_addr = 17'h00300; cpu_we = 1'b0; cpu_addr = 17'h02000;
    for (int k = 0; k < 11; k++) begin
      blank    = (k >= 4 && k <= 7);
      disp_req = (k >= 1 && k <= 7);
      cpu_req  = (k >= 1 && k <= 6);
      #3;
      checks++;
      if ({cpu_gnt, disp_gnt} !== {exp_cpu_gnt(), exp_disp_gnt()}) begin
        failures++;
        $display("[TB] FAIL blank_gnt_model cyc=%0d got %b%b required %b%b", cyc, cpu_gnt, disp_gnt, exp_cpu_gnt(), exp_disp_gnt());
      end
      if (k >= 1 && k <= 7) begin
        checks++;
        if ({cpu_gnt, disp_gnt} !== ((k >= 4 && k <= 6) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("[TB] FAIL blank_gnt k=%0d got %b%b required %b", k, cpu_gnt, disp_gnt,
                   (k >= 4 && k <= 6) ? 2'b10 : 2'b01);
        end
      end
      checks++;
      if (cpu_rvalid !== exp_rv(1'b1) || cpu_rdata !== exp_rd(1'b1) ||
          disp_rvalid !== exp_rv(1'b0) || disp_rdata !== exp_rd(1'b0)) begin
        failures++;
        $display("[TB] FAIL blank_return cyc=%0d got crv=%b crd=%h drv=%b drd=%h required %b %h %b %h", cyc,
                 cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata, exp_rv(1'b1), exp_rd(1'b1), exp_rv(1'b0), exp_rd(1'b0));
      end
      tick();
      if (m_dg) disp_addr++;
      if (m_cg) cpu_addr++;
    end
  endtask

  task automatic test_random();
    blank = 1'b0; cpu_req = 1'b0; disp_req = 1'b0;
    for (int k = 0; k < 303; k++) begin
      if (k >= 300) begin
        cpu_req = 1'b0; disp_req = 1'b0;
      end
      #3;
      checks++;
      if ({cpu_gnt, disp_gnt} !== {exp_cpu_gnt(), exp_disp_gnt()}) begin
        failures++;
        $display("[TB] FAIL random_gnt cyc=%0d got %b%b required %b%b", cyc, cpu_gnt, disp_gnt, exp_cpu_gnt(), exp_disp_gnt());
      end
      checks++;
      if (cpu_rvalid !== exp_rv(1'b1) || cpu_rdata !== exp_rd(1'b1) ||
          disp_rvalid !== exp_rv(1'b0) || disp_rdata !== exp_rd(1'b0)) begin
        failures++;
        $display("[TB] FAIL random_return cyc=%0d got crv=%b crd=%h drv=%b drd=%h required %b %h %b %h", cyc,
                 cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata, exp_rv(1'b1), exp_rd(1'b1), exp_rv(1'b0), exp_rd(1'b0));
      end
      tick();
      if (k >= 299) continue;
      if (m_cg) cpu_req = 1'b0;
      if (m_dg) disp_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 63)); cpu_wdata = DW'($urandom);
      end
      if (!disp_req && $urandom_range(0, 1) == 0) begin
        disp_req = 1'b1; disp_addr = AW'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 9) == 0) blank = !blank;
    end
  endtask

  initial begin
    rst = 1'b1; blank = 1'b0; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_back_to_back();
    test_starvation();
    test_blank_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM between two requesters:
  - the display fetch path, which refills pixel line data from the hcount/vcount timing;
  - the CPU/host port, which reads and writes framebuffer contents.
- Display has priority during active video. CPU has priority during blanking.
- A starvation counter guarantees CPU service within a bounded number of cycles.
- Sits between the video timing/line-fetch logic and the VRAM block, in the clk_pix domain.

Parameters:
- AW, 17, VRAM word address width.
- DW, 16, VRAM data width.
- STARVE_MAX, 8, maximum consecutive cycles a pending CPU request may be refused before it is forced through (legal range 1..255).

Ports:
- clk_i  in  1  pixel clock.
- rst_i  in  1  reset: asynchronous, active-high.
- blank_i  in  1  high outside the display-active region (~de from timing core).
- disp_req_i  in  1  display read request.
- disp_addr_i  in  AW  display read address.
- disp_gnt_o  out  1  display request accepted this cycle.
- disp_rvalid_o  out  1  display read data valid.
- disp_rdata_o  out  DW  display read data.
- cpu_req_i  in  1  CPU request.
- cpu_we_i  in  1  CPU write (1) / read (0).
- cpu_addr_i  in  AW  CPU address.
- cpu_wdata_i  in  DW  CPU write data.
- cpu_gnt_o  out  1  CPU request accepted this cycle.
- cpu_rvalid_o  out  1  CPU read data valid.
- cpu_rdata_o  out  DW  CPU read data.
- mem_en_o  out  1  VRAM access strobe.
- mem_we_o  out  1  VRAM write enable.
- mem_addr_o  out  AW  VRAM address.
- mem_wdata_o  out  DW  VRAM write data.
- mem_rdata_i  in  DW  VRAM read data, valid 1 cycle after a read strobe.

Behaviour:

Reset
- Asynchronous, active-high.
- While rst_i is high, all registered outputs are 0: mem_*, both rvalid, both rdata, starve count, in-flight tags.
- The gnt outputs are forced to 0.
- Reset mid-access discards any in-flight read: no rvalid pulse follows after reset release.

Handshake
- A requester holds req/addr/we/wdata stable until it sees gnt.
- Transfer occurs on a cycle where req && gnt.
- gnt is combinational from the current inputs and the registered starve count.
- At most one grant per cycle. Back-to-back grants to either side are allowed, giving one access per cycle.

Grant priority (evaluated each cycle)
1. CPU is granted if cpu_req_i && (blank_i || starve_cnt == STARVE_MAX || !disp_req_i).
2. Otherwise display is granted if disp_req_i.
3. Otherwise no grant.

Starvation counter
- Width $clog2(STARVE_MAX+1).
- Increments when cpu_req_i && !cpu_gnt_o, saturating at STARVE_MAX.
- Clears to 0 on CPU grant, or when cpu_req_i is low.

Memory pipeline
- Grant in cycle N → mem_en_o=1 with the granted addr/we/wdata registered in cycle N+1.
- Cycles with no grant → mem_en_o=0, mem_we_o=0. Address/data hold their previous values.
- Display accesses always have mem_we_o=0.
- A 1-bit owner tag and a read flag travel with the access.

Read return
- mem_rdata_i is captured in cycle N+2.
- The owner's rvalid pulses high for exactly one cycle (N+2) with rdata equal to the captured word.
- Read latency from grant to rvalid is 2 cycles.
- rdata registers hold their value between pulses.

Writes
- A CPU write produces no rvalid.

Simultaneous events
- Both requesters active in active video: display wins until the starve count hits STARVE_MAX. The CPU then wins one cycle, the counter clears, and display resumes.
- blank_i changing in the same cycle as a request takes effect immediately, because the grant is combinational.

Test Plan:
1. Reset, then idle: all outputs 0. Assert rst_i during an outstanding read at N+1 → no rvalid after release.
2. CPU write addr 0x00010 data 0xBEEF with blank_i=1 → cpu_gnt_o same cycle. Next cycle mem_en_o=1, mem_we_o=1, mem_addr_o=0x00010, mem_wdata_o=0xBEEF. No cpu_rvalid_o.
3. CPU read addr 0x00010, memory model returns 0xBEEF → cpu_rvalid_o high exactly 2 cycles after grant with cpu_rdata_o=0xBEEF. disp_rvalid_o stays 0.
4. blank_i=0, disp_req_i held high with incrementing addresses, cpu_req_i held high, STARVE_MAX=8 → 8 display grants, then 1 CPU grant, repeating. Display rvalid stream in address order, 2-cycle latency.
5. Both requesters active, blank_i toggles 0→1 → CPU granted in the first blank cycle. Display is stalled while CPU requests continue, then resumes.
6. Back-to-back display reads 0x100..0x103 alone → mem_en_o high 4 consecutive cycles. disp_rvalid_o high 4 consecutive cycles with the matching data.
